// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared state type, lane count and lane-slicing helpers for the memory port arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam int LANES = 2;
    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_SIZE_W = 4;
    function automatic int lane_lo(logic lane, int w);
        return lane ? w : 0;
    endfunction
endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-way round-robin select favouring the lane not granted last
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [LANES-1:0] eligible,
    input  logic             last_grant,
    output logic             valid,
    output logic             grant
);
    assign valid = |eligible;
    assign grant = eligible[~last_grant] ? ~last_grant : last_grant;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between two lanes, one transaction at a time
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SIZE_W = DEF_SIZE_W,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [LANES-1:0]          ch_oe,
    input  logic [LANES-1:0]          ch_we,
    input  logic [LANES*ADDR_W-1:0]   ch_addr,
    input  logic [LANES*DATA_W-1:0]   ch_wdata,
    input  logic [LANES*SIZE_W-1:0]   ch_size,
    output logic [LANES*DATA_W-1:0]   ch_rdata,
    output logic [LANES-1:0]          ch_rdy,
    output logic                      mem_oe,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic [SIZE_W-1:0]         mem_size,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [LANES-1:0]          proto_err
);
    state_t state;
    logic grant, last_grant, is_wr, pick_valid, pick;
    logic [3:0] cnt;
    logic [LANES-1:0] eligible;

    assign eligible = (ch_oe ^ ch_we) & ~proto_err;

    rr_pick2 u_pick (
        .eligible   (eligible),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .grant      (pick)
    );

    // Arbitration and fixed-latency sequencing; the mem_* registers double as the request latch
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            is_wr      <= 1'b0;
            cnt        <= '0;
            ch_rdata   <= '0;
            ch_rdy     <= '0;
            mem_oe     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_size   <= '0;
            proto_err  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    proto_err <= proto_err | (ch_oe & ch_we);
                    if (pick_valid) begin
                        grant     <= pick;
                        is_wr     <= ch_we[pick];
                        mem_oe    <= ~ch_we[pick];
                        mem_we    <= ch_we[pick];
                        mem_addr  <= ch_addr[lane_lo(pick, ADDR_W) +: ADDR_W];
                        mem_wdata <= ch_wdata[lane_lo(pick, DATA_W) +: DATA_W];
                        mem_size  <= ch_size[lane_lo(pick, SIZE_W) +: SIZE_W];
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_oe    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    mem_size  <= '0;
                    cnt       <= is_wr ? 4'(WR_LAT - 1) : 4'(RD_LAT - 1);
                    state     <= WAIT;
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        ch_rdy   <= {grant, ~grant};
                        ch_rdata <= {{DATA_W{grant & ~is_wr}} & mem_rdata,
                                     {DATA_W{~grant & ~is_wr}} & mem_rdata};
                        state    <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    ch_rdy     <= '0;
                    ch_rdata   <= '0;
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency, protocol errors and reset abort
module tb_mem_port_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  ch_oe = '0, ch_we = '0;
    logic [13:0] ch_addr = '0;
    logic [15:0] ch_wdata = '0;
    logic [7:0]  ch_size = '0;
    logic [7:0]  mem_rdata = '0;
    logic [15:0] ch_rdata, ch_rdata_b;
    logic [1:0]  ch_rdy, ch_rdy_b, proto_err, proto_err_b;
    logic        mem_oe, mem_we, mem_oe_b, mem_we_b;
    logic [6:0]  mem_addr, mem_addr_b;
    logic [7:0]  mem_wdata, mem_wdata_b;
    logic [3:0]  mem_size, mem_size_b;
    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    mem_port_arbiter dut (
        .clock(clock), .reset(reset), .ch_oe(ch_oe), .ch_we(ch_we), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_size(ch_size), .ch_rdata(ch_rdata), .ch_rdy(ch_rdy),
        .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_rdata(mem_rdata), .proto_err(proto_err)
    );

    mem_port_arbiter #(.RD_LAT(5), .WR_LAT(3)) dut_b (
        .clock(clock), .reset(reset), .ch_oe(ch_oe), .ch_we(ch_we), .ch_addr(ch_addr),
        .ch_wdata(ch_wdata), .ch_size(ch_size), .ch_rdata(ch_rdata_b), .ch_rdy(ch_rdy_b),
        .mem_oe(mem_oe_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_size(mem_size_b), .mem_rdata(mem_rdata), .proto_err(proto_err_b)
    );

    task automatic do_reset;
        ch_oe = '0; ch_we = '0; ch_addr = '0; ch_wdata = '0; ch_size = '0; mem_rdata = '0;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset;
        logic [45:0] all_out;
        ch_oe = '0; ch_we = '0;
        reset = 1'b0;
        @(negedge clock);
        all_out = {ch_rdata, ch_rdy, mem_oe, mem_we, mem_addr, mem_wdata, mem_size, proto_err};
        total++;
        if (all_out !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", all_out);
        end
        reset = 1'b1;
        repeat (3) @(negedge clock);
        all_out = {ch_rdata, ch_rdy, mem_oe, mem_we, mem_addr, mem_wdata, mem_size, proto_err};
        total++;
        if (all_out !== '0) begin
            bad++;
            $display("FAIL idle_outputs got=%h exp=0", all_out);
        end
    endtask

    task automatic test_read_lane0;
        logic [8:0] e_mem;
        logic [1:0] e_rdy;
        logic [15:0] e_rd;
        do_reset;
        ch_oe = 2'b01; ch_addr = 14'h0005;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            e_mem = (c == 1) ? {2'b10, 7'h05} : 9'h0;
            e_rdy = (c == 4) ? 2'b01 : 2'b00;
            e_rd  = (c == 4) ? 16'h00A5 : 16'h0;
            total++;
            if ({mem_oe, mem_we, mem_addr} !== e_mem) begin
                bad++;
                $display("FAIL rd0_mem c=%0d got=%h exp=%h", c, {mem_oe, mem_we, mem_addr}, e_mem);
            end
            total++;
            if ({ch_rdy, ch_rdata} !== {e_rdy, e_rd}) begin
                bad++;
                $display("FAIL rd0_resp c=%0d got=%h/%h exp=%h/%h", c, ch_rdy, ch_rdata, e_rdy, e_rd);
            end
            mem_rdata = (c == 3) ? 8'hA5 : 8'h00;
            if (c == 4) ch_oe = 2'b00;
        end
    endtask

    task automatic test_write_lane1;
        logic [20:0] e_mem;
        logic [17:0] e_resp;
        do_reset;
        ch_we = 2'b10; ch_addr = {7'h10, 7'h00}; ch_wdata = 16'h3C00; ch_size = 8'h80;
        mem_rdata = 8'hFF;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            e_mem  = (c == 1) ? {2'b01, 7'h10, 8'h3C, 4'h8} : 21'h0;
            e_resp = (c == 3) ? {2'b10, 16'h0000} : 18'h0;
            total++;
            if ({mem_oe, mem_we, mem_addr, mem_wdata, mem_size} !== e_mem) begin
                bad++;
                $display("FAIL wr1_mem c=%0d got=%h exp=%h", c,
                         {mem_oe, mem_we, mem_addr, mem_wdata, mem_size}, e_mem);
            end
            total++;
            if ({ch_rdy, ch_rdata} !== e_resp) begin
                bad++;
                $display("FAIL wr1_resp c=%0d got=%h exp=%h", c, {ch_rdy, ch_rdata}, e_resp);
            end
            if (c == 3) ch_we = 2'b00;
        end
    endtask

    task automatic test_back_to_back;
        logic [8:0] e_mem;
        logic [17:0] e_resp;
        do_reset;
        ch_oe = 2'b11; ch_addr = {7'h02, 7'h01};
        for (int c = 1; c <= 21; c++) begin
            @(negedge clock);
            e_mem  = (c == 1 || c == 11) ? {2'b10, 7'h01} :
                     (c == 6 || c == 16) ? {2'b10, 7'h02} : 9'h0;
            e_resp = (c == 4)  ? {2'b01, 16'h0003} :
                     (c == 9)  ? {2'b10, 16'h0800} :
                     (c == 14) ? {2'b01, 16'h000D} :
                     (c == 19) ? {2'b10, 16'h1200} : 18'h0;
            total++;
            if ({mem_oe, mem_we, mem_addr} !== e_mem) begin
                bad++;
                $display("FAIL b2b_mem c=%0d got=%h exp=%h", c, {mem_oe, mem_we, mem_addr}, e_mem);
            end
            total++;
            if ({ch_rdy, ch_rdata} !== e_resp) begin
                bad++;
                $display("FAIL b2b_resp c=%0d got=%h exp=%h", c, {ch_rdy, ch_rdata}, e_resp);
            end
            mem_rdata = 8'(c);
            if (c == 19) ch_oe = 2'b00;
        end
    endtask

    task automatic test_proto_err;
        logic [8:0] e_mem;
        logic [17:0] e_resp;
        do_reset;
        ch_oe = 2'b11; ch_we = 2'b01; ch_addr = {7'h22, 7'h33}; mem_rdata = 8'h77;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clock);
            e_mem  = (c == 1) ? {2'b10, 7'h22} : 9'h0;
            e_resp = (c == 4) ? {2'b10, 16'h7700} : 18'h0;
            total++;
            if (proto_err !== 2'b01) begin
                bad++;
                $display("FAIL perr_flag c=%0d got=%b exp=01", c, proto_err);
            end
            total++;
            if ({mem_oe, mem_we, mem_addr} !== e_mem) begin
                bad++;
                $display("FAIL perr_mem c=%0d got=%h exp=%h", c, {mem_oe, mem_we, mem_addr}, e_mem);
            end
            total++;
            if ({ch_rdy, ch_rdata} !== e_resp) begin
                bad++;
                $display("FAIL perr_resp c=%0d got=%h exp=%h", c, {ch_rdy, ch_rdata}, e_resp);
            end
            if (c == 2) ch_we = 2'b00;
            if (c == 4) ch_oe = 2'b01;
        end
        ch_oe = 2'b00;
    endtask

    task automatic test_reset_abort;
        logic [45:0] all_out;
        logic [8:0] e_mem;
        logic [17:0] e_resp;
        do_reset;
        ch_oe = 2'b01; ch_addr = 14'h0009; mem_rdata = 8'h5A;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        all_out = {ch_rdata, ch_rdy, mem_oe, mem_we, mem_addr, mem_wdata, mem_size, proto_err};
        total++;
        if (all_out !== '0) begin
            bad++;
            $display("FAIL abort_outputs got=%h exp=0", all_out);
        end
        for (int c = 3; c <= 5; c++) begin
            @(negedge clock);
            total++;
            if ({ch_rdy, mem_oe} !== 3'b000) begin
                bad++;
                $display("FAIL abort_hold c=%0d got=%b exp=000", c, {ch_rdy, mem_oe});
            end
        end
        reset = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            e_mem  = (c == 1) ? {2'b10, 7'h09} : 9'h0;
            e_resp = (c == 4) ? {2'b01, 16'h005A} : 18'h0;
            total++;
            if ({mem_oe, mem_we, mem_addr} !== e_mem) begin
                bad++;
                $display("FAIL reissue_mem c=%0d got=%h exp=%h", c, {mem_oe, mem_we, mem_addr}, e_mem);
            end
            total++;
            if ({ch_rdy, ch_rdata} !== e_resp) begin
                bad++;
                $display("FAIL reissue_resp c=%0d got=%h exp=%h", c, {ch_rdy, ch_rdata}, e_resp);
            end
            if (c == 4) ch_oe = 2'b00;
        end
    endtask

    task automatic test_long_latency;
        logic [20:0] e_mem;
        logic [17:0] e_resp;
        do_reset;
        ch_oe = 2'b01; ch_addr = 14'h0003;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clock);
            e_mem  = (c == 1) ? {2'b10, 7'h03, 8'h00, 4'h0} : 21'h0;
            e_resp = (c == 7) ? {2'b01, 16'h0086} : 18'h0;
            total++;
            if ({mem_oe_b, mem_we_b, mem_addr_b, mem_wdata_b, mem_size_b} !== e_mem) begin
                bad++;
                $display("FAIL lat_rd_mem c=%0d got=%h exp=%h", c,
                         {mem_oe_b, mem_we_b, mem_addr_b, mem_wdata_b, mem_size_b}, e_mem);
            end
            total++;
            if ({ch_rdy_b, ch_rdata_b} !== e_resp) begin
                bad++;
                $display("FAIL lat_rd_resp c=%0d got=%h exp=%h", c, {ch_rdy_b, ch_rdata_b}, e_resp);
            end
            mem_rdata = 8'(8'h80 + c);
            if (c == 7) ch_oe = 2'b00;
        end
        do_reset;
        ch_we = 2'b10; ch_addr = {7'h11, 7'h00}; ch_wdata = 16'h9900; ch_size = 8'h80;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clock);
            e_mem  = (c == 1) ? {2'b01, 7'h11, 8'h99, 4'h8} : 21'h0;
            e_resp = (c == 5) ? {2'b10, 16'h0000} : 18'h0;
            total++;
            if ({mem_oe_b, mem_we_b, mem_addr_b, mem_wdata_b, mem_size_b} !== e_mem) begin
                bad++;
                $display("FAIL lat_wr_mem c=%0d got=%h exp=%h", c,
                         {mem_oe_b, mem_we_b, mem_addr_b, mem_wdata_b, mem_size_b}, e_mem);
            end
            total++;
            if ({ch_rdy_b, ch_rdata_b} !== e_resp) begin
                bad++;
                $display("FAIL lat_wr_resp c=%0d got=%h exp=%h", c, {ch_rdy_b, ch_rdata_b}, e_resp);
            end
            mem_rdata = 8'hEE;
            if (c == 5) ch_we = 2'b00;
        end
    endtask

    initial begin
        #1;
        test_reset;
        test_read_lane0;
        test_write_lane1;
        test_back_to_back;
        test_proto_err;
        test_reset_abort;
        test_long_latency;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
